core_region_readout_seq: RTL and testbench
==========================================

CORE_REGION_READOUT_SEQ -- requirements
Module: core_region_readout_seq

Interface
REQ-001 SHALL have parameter DATA_BITS, default 24: width of the region data bus.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of 2): output FIFO depth in words.
REQ-003 SHALL have parameter TOK_SETTLE, default 2 (range 1..15): cycles waited after token/read activity before TokOut is sampled.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum region reads per request.
REQ-005 Clk  input  1  single clock; all logic on rising edge.
REQ-006 Reset  input  1  synchronous, active-low reset.
REQ-007 ReqValid  input  1  readout request for one trigger ID.
REQ-008 ReqTrigId  input  5  trigger ID to read out.
REQ-009 ReqReady  output  1  request accepted when ReqValid & ReqReady.
REQ-010 TrigIdReq  output  5  trigger ID broadcast to the region chain.
REQ-011 TokIn  output  1  token into the first region of the chain.
REQ-012 TokOut  input  1  token out of the last region of the chain.
REQ-013 Read  output  1  read strobe to the regions.
REQ-014 DataToCore  input  DATA_BITS  OR-bus of region data (zero when no region is enabled).
REQ-015 OutValid / OutReady  output / input  1 / 1  output stream handshake.
REQ-016 OutData  output  DATA_BITS+6  [DATA_BITS+5]=trailer flag, [DATA_BITS+4:DATA_BITS]=trigger ID, [DATA_BITS-1:0]=hit word or trailer count.
REQ-017 Busy  output  1  high whenever the state is not IDLE.
REQ-018 TimeoutErr  output  1  one-cycle pulse on read-count overflow.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, SETTLE, READ, CAPTURE, TRAILER.
REQ-020 In IDLE, ReqReady SHALL be 1 only when the state is IDLE; on acceptance, the module SHALL latch ReqTrigId into TrigIdReq, clear the hit counter, and go to ISSUE.
REQ-021 In ISSUE, TokIn SHALL be driven 1 and held until TRAILER is left; the FSM SHALL go to SETTLE with the settle counter loaded to TOK_SETTLE.
REQ-022 In SETTLE, the counter SHALL decrement each cycle; at 0 the FSM SHALL sample TokOut: if TokOut=1, go to TRAILER; if TokOut=0 and at least 2 FIFO slots are free, go to READ; otherwise stay in SETTLE.
REQ-023 In READ, Read SHALL be 1 for exactly one cycle, then the FSM SHALL go to CAPTURE.
REQ-024 In CAPTURE, the module SHALL push {0, TrigIdReq, DataToCore} into the FIFO, increment the 8-bit hit counter, and return to SETTLE with the counter reloaded; Read SHALL be 0.
REQ-025 If the hit counter reaches TIMEOUT in CAPTURE, the module SHALL pulse TimeoutErr and go to TRAILER regardless of TokOut.
REQ-026 In TRAILER, the module SHALL wait for 1 free FIFO slot, then push {1, TrigIdReq, zero-extended hit count}, deassert TokIn, and return to IDLE.
REQ-027 The FIFO SHALL be first-word-fall-through: OutValid = not empty, and OutData = head word.
REQ-028 A pop SHALL occur on OutValid & OutReady; a simultaneous push and pop when full SHALL never occur, because of the 2-slot reservation.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be tracked with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-031 Outputs SHALL be registered, except OutValid/OutData, which come from the FIFO head.

Reset
REQ-032 While Reset=0 at a clock edge, the module SHALL set: state IDLE, TokIn=0, Read=0, TrigIdReq=0, TimeoutErr=0, FIFO empty (OutValid=0), counters 0, ReqReady=0 during reset and 1 on the first cycle after release.
REQ-033 Reset asserted mid-readout SHALL abandon the event with no trailer, and the FIFO contents SHALL be discarded.

Verification
REQ-034 Empty event: request ID 7, TokOut=1 throughout -> no Read pulse; single word trailer=1, ID=7, count=0; Busy falls after the trailer push.
REQ-035 Three hits: TokOut=0 for 3 settle samples, then 1; DataToCore = 0xA1, 0xB2, 0xC3 on the CAPTURE cycles -> 3 Read pulses and 4 output words in order, with trailer count=3.
REQ-036 Backpressure: OutReady=0, FIFO_DEPTH=8, TokOut held 0 -> reads stop at occupancy 7; no Read is issued while fewer than 2 slots are free; releasing OutReady resumes with no lost or duplicated words.
REQ-037 Timeout: TIMEOUT=4, TokOut stuck 0 -> 4 hits, a TimeoutErr pulse, then a trailer with count=4.
REQ-038 Reset mid-event: drive Reset=0 during READ -> next cycle Read=0, TokIn=0, OutValid=0; a new request after release completes normally.
REQ-039 Request during Busy: ReqValid held high throughout an event -> exactly one acceptance per event; the second request is accepted in the first IDLE cycle after the trailer.

Source files
------------

// File: rtl/core_region_readout_seq.sv
// ============================================================================
// core_region_readout_seq: token-driven region chain readout with FWFT FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_region_readout_seq #(
  parameter int DATA_BITS  = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int TOK_SETTLE = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 Clk_i,
  input  logic                 Reset_ni,
  input  logic                 ReqValid_i,
  input  logic [4:0]           ReqTrigId_i,
  output logic                 ReqReady_o,
  output logic [4:0]           TrigIdReq_o,
  output logic                 TokIn_o,
  input  logic                 TokOut_i,
  output logic                 Read_o,
  input  logic [DATA_BITS-1:0] DataToCore_i,
  output logic                 OutValid_o,
  input  logic                 OutReady_i,
  output logic [DATA_BITS+5:0] OutData_o,
  output logic                 Busy_o,
  output logic                 TimeoutErr_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = DATA_BITS + 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_READ    = 3'd3,
    S_CAPTURE = 3'd4,
    S_TRAILER = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      trig_q, trig_d;
  logic [7:0]      hit_q, hit_d;
  logic [3:0]      settle_q, settle_d;
  logic            ReqReady_q, TokIn_q, Read_q, Busy_q, TimeoutErr_q;

  logic [OW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;

  logic            w_push, w_pop, w_tmo;
  logic [OW-1:0]   w_push_data;
  logic [7:0]      w_hit_inc;

  assign w_hit_inc = hit_q + 8'd1;
  assign w_pop     = (cnt_q != '0) && OutReady_i;

  always_comb begin
    state_d     = state_q;
    trig_d      = trig_q;
    hit_d       = hit_q;
    settle_d    = settle_q;
    w_push      = 1'b0;
    w_push_data = '0;
    w_tmo       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ReqValid_i && ReqReady_q) begin
          trig_d  = ReqTrigId_i;
          hit_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        settle_d = 4'(TOK_SETTLE);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        // Two free slots keep room for this hit plus the trailer.
        if (settle_q != 4'd0)
          settle_d = settle_q - 4'd1;
        else if (TokOut_i)
          state_d = S_TRAILER;
        else if (cnt_q <= CW'(FIFO_DEPTH - 2))
          state_d = S_READ;
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        w_push      = 1'b1;
        w_push_data = {1'b0, trig_q, DataToCore_i};
        hit_d       = w_hit_inc;
        if (w_hit_inc == 8'(TIMEOUT)) begin
          w_tmo   = 1'b1;
          state_d = S_TRAILER;
        end else begin
          settle_d = 4'(TOK_SETTLE);
          state_d  = S_SETTLE;
        end
      end
      S_TRAILER: begin
        if (cnt_q < CW'(FIFO_DEPTH)) begin
          w_push      = 1'b1;
          w_push_data = {1'b1, trig_q, DATA_BITS'(hit_q)};
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_ni) begin
      state_q      <= S_IDLE;
      trig_q       <= '0;
      hit_q        <= '0;
      settle_q     <= '0;
      ReqReady_q   <= 1'b0;
      TokIn_q      <= 1'b0;
      Read_q       <= 1'b0;
      Busy_q       <= 1'b0;
      TimeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      hit_q        <= hit_d;
      settle_q     <= settle_d;
      ReqReady_q   <= (state_d == S_IDLE);
      TokIn_q      <= (state_d != S_IDLE);
      Read_q       <= (state_d == S_READ);
      Busy_q       <= (state_d != S_IDLE);
      TimeoutErr_q <= w_tmo;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + AW'(1);
      if (w_pop)  rptr_q <= rptr_q + AW'(1);
      if (w_push && !w_pop)      cnt_q <= cnt_q + CW'(1);
      else if (!w_push && w_pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk_i) begin
    if (w_push) mem_q[wptr_q] <= w_push_data;
  end

  assign ReqReady_o   = ReqReady_q;
  assign TrigIdReq_o  = trig_q;
  assign TokIn_o      = TokIn_q;
  assign Read_o       = Read_q;
  assign Busy_o       = Busy_q;
  assign TimeoutErr_o = TimeoutErr_q;
  assign OutValid_o   = (cnt_q != '0);
  assign OutData_o    = mem_q[rptr_q];

endmodule

`default_nettype wire

// File: tb/tb_core_region_readout_seq.sv
// ============================================================================
// tb_core_region_readout_seq: directed scenario bench for the readout sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_core_region_readout_seq;

  localparam int DW = 24;
  localparam int OW = DW + 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_valid2;
  logic [4:0]    req_id;
  logic          tok_out, tok_out2;
  logic [DW-1:0] data_in;
  logic          out_ready, out_ready2;

  logic          req_ready, tok_in, rd, out_valid, busy, tmo_err;
  logic [4:0]    trig_id;
  logic [OW-1:0] out_data;
  logic          req_ready2, tok_in2, rd2, out_valid2, busy2, tmo_err2;
  logic [4:0]    trig_id2;
  logic [OW-1:0] out_data2;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [OW-1:0] words[$];
  logic [OW-1:0] words2[$];
  int            n_reads;
  logic [DW-1:0] hit_tbl[8];
  logic          busy_at_first;

  always #5 clk = ~clk;

  core_region_readout_seq #(.DATA_BITS(DW), .FIFO_DEPTH(8), .TOK_SETTLE(2), .TIMEOUT(255)) dut (
    .Clk_i(clk), .Reset_ni(rst_n), .ReqValid_i(req_valid), .ReqTrigId_i(req_id),
    .ReqReady_o(req_ready), .TrigIdReq_o(trig_id), .TokIn_o(tok_in), .TokOut_i(tok_out),
    .Read_o(rd), .DataToCore_i(data_in), .OutValid_o(out_valid), .OutReady_i(out_ready),
    .OutData_o(out_data), .Busy_o(busy), .TimeoutErr_o(tmo_err)
  );

  core_region_readout_seq #(.DATA_BITS(DW), .FIFO_DEPTH(8), .TOK_SETTLE(2), .TIMEOUT(4)) dut_to (
    .Clk_i(clk), .Reset_ni(rst_n), .ReqValid_i(req_valid2), .ReqTrigId_i(5'd9),
    .ReqReady_o(req_ready2), .TrigIdReq_o(trig_id2), .TokIn_o(tok_in2), .TokOut_i(tok_out2),
    .Read_o(rd2), .DataToCore_i(data_in), .OutValid_o(out_valid2), .OutReady_i(out_ready2),
    .OutData_o(out_data2), .Busy_o(busy2), .TimeoutErr_o(tmo_err2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] wq(input int i);
    if (i < words.size()) return words[i];
    return 'x;
  endfunction

  // One readout on the main DUT; TokOut turns high once nhits Read strobes were seen.
  task automatic run_event(input logic [4:0] id, input int nhits, input int max_cyc, output bit ok);
    bit hand = 0;
    ok = 0;
    words.delete();
    n_reads = 0;
    busy_at_first = 1'bx;
    req_id = id;
    req_valid = 1'b1;
    out_ready = 1'b1;
    tok_out = (nhits == 0);
    for (int c = 0; c < max_cyc; c++) begin
      if (hand && !busy && !out_valid) begin
        ok = 1;
        break;
      end
      if (hand) req_valid = 1'b0;
      if (req_valid && req_ready) hand = 1;
      if (rd) begin
        data_in = hit_tbl[n_reads % 8];
        n_reads++;
      end
      tok_out = (n_reads >= nhits);
      if (out_valid && out_ready) begin
        if (words.size() == 0) busy_at_first = busy;
        words.push_back(out_data);
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (tok_in !== 1'b0) begin n_fail++; $display("FAIL rst_tok_in: got %b want 0", tok_in); end
    n_cmp++; if (rd !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b want 0", rd); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (trig_id !== 5'd0) begin n_fail++; $display("FAIL rst_trig_id: got %0d want 0", trig_id); end
    n_cmp++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b want 0", tmo_err); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_empty_event;
    bit ok;
    run_event(5'd7, 0, 60, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", ok); end
    n_cmp++; if (n_reads != 0) begin n_fail++; $display("FAIL empty_reads: got %0d want 0", n_reads); end
    n_cmp++; if (words.size() != 1) begin n_fail++; $display("FAIL empty_nwords: got %0d want 1", words.size()); end
    n_cmp++; if (wq(0) !== {1'b1, 5'd7, 24'd0}) begin n_fail++; $display("FAIL empty_trailer: got %h want %h", wq(0), {1'b1, 5'd7, 24'd0}); end
    n_cmp++; if (busy_at_first !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b want 0", busy_at_first); end
  endtask

  task automatic test_three_hits;
    bit ok;
    hit_tbl[0] = 24'hA1; hit_tbl[1] = 24'hB2; hit_tbl[2] = 24'hC3;
    run_event(5'd19, 3, 120, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hits_done: got %b want 1", ok); end
    n_cmp++; if (n_reads != 3) begin n_fail++; $display("FAIL hits_reads: got %0d want 3", n_reads); end
    n_cmp++; if (words.size() != 4) begin n_fail++; $display("FAIL hits_nwords: got %0d want 4", words.size()); end
    n_cmp++; if (wq(0) !== {1'b0, 5'd19, 24'hA1}) begin n_fail++; $display("FAIL hits_w0: got %h want %h", wq(0), {1'b0, 5'd19, 24'hA1}); end
    n_cmp++; if (wq(1) !== {1'b0, 5'd19, 24'hB2}) begin n_fail++; $display("FAIL hits_w1: got %h want %h", wq(1), {1'b0, 5'd19, 24'hB2}); end
    n_cmp++; if (wq(2) !== {1'b0, 5'd19, 24'hC3}) begin n_fail++; $display("FAIL hits_w2: got %h want %h", wq(2), {1'b0, 5'd19, 24'hC3}); end
    n_cmp++; if (wq(3) !== {1'b1, 5'd19, 24'd3}) begin n_fail++; $display("FAIL hits_trailer: got %h want %h", wq(3), {1'b1, 5'd19, 24'd3}); end
    n_cmp++; if (trig_id !== 5'd19) begin n_fail++; $display("FAIL hits_trig_id: got %0d want 19", trig_id); end
  endtask

  task automatic test_backpressure;
    int viol = 0;
    words.delete();
    n_reads = 0;
    for (int k = 0; k < 8; k++) hit_tbl[k] = DW'(24'h100 + k);
    out_ready = 1'b0;
    tok_out = 1'b0;
    req_id = 5'd5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 90; c++) begin
      if (rd) begin
        if (n_reads > 6) viol++;
        data_in = hit_tbl[n_reads % 8];
        n_reads++;
      end
      tick();
    end
    n_cmp++; if (n_reads != 7) begin n_fail++; $display("FAIL bp_reads: got %0d want 7", n_reads); end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL bp_read_when_full: got %0d want 0", viol); end
    n_cmp++; if ({busy, tok_in, out_valid} !== 3'b111) begin n_fail++; $display("FAIL bp_stall: got %b want 111", {busy, tok_in, out_valid}); end
    tok_out = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (!busy && !out_valid) break;
      if (rd) n_reads++;
      if (out_valid && out_ready) words.push_back(out_data);
      tick();
    end
    n_cmp++; if (words.size() != 8) begin n_fail++; $display("FAIL bp_nwords: got %0d want 8", words.size()); end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (wq(k) !== {1'b0, 5'd5, DW'(24'h100 + k)}) begin
        n_fail++; $display("FAIL bp_word%0d: got %h want %h", k, wq(k), {1'b0, 5'd5, DW'(24'h100 + k)});
      end
    end
    n_cmp++; if (wq(7) !== {1'b1, 5'd5, 24'd7}) begin n_fail++; $display("FAIL bp_trailer: got %h want %h", wq(7), {1'b1, 5'd5, 24'd7}); end
    n_cmp++; if (n_reads != 7) begin n_fail++; $display("FAIL bp_reads_after: got %0d want 7", n_reads); end
  endtask

  task automatic test_timeout;
    int reads2 = 0;
    int pulses = 0;
    words2.delete();
    tok_out2 = 1'b0;
    out_ready2 = 1'b1;
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (!busy2 && !out_valid2) break;
      if (rd2) reads2++;
      if (tmo_err2) pulses++;
      if (out_valid2 && out_ready2) words2.push_back(out_data2);
      tick();
    end
    n_cmp++; if (reads2 != 4) begin n_fail++; $display("FAIL to_reads: got %0d want 4", reads2); end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    n_cmp++; if (words2.size() != 5) begin n_fail++; $display("FAIL to_nwords: got %0d want 5", words2.size()); end
    if (words2.size() == 5) begin
      n_cmp++; if (words2[4] !== {1'b1, 5'd9, 24'd4}) begin n_fail++; $display("FAIL to_trailer: got %h want %h", words2[4], {1'b1, 5'd9, 24'd4}); end
      n_cmp++; if (words2[0][OW-1] !== 1'b0) begin n_fail++; $display("FAIL to_hit_flag: got %b want 0", words2[0][OW-1]); end
    end
    n_cmp++; if ({tok_in2, trig_id2} !== {1'b0, 5'd9}) begin n_fail++; $display("FAIL to_end: got %b want %b", {tok_in2, trig_id2}, {1'b0, 5'd9}); end
  endtask

  task automatic test_reset_mid_event;
    int seen = 0;
    bit ok;
    out_ready = 1'b0;
    tok_out = 1'b0;
    req_id = 5'd2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rd) seen++;
      if (seen == 2) break;
      tick();
    end
    n_cmp++; if (seen != 2) begin n_fail++; $display("FAIL mid_reach_read: got %0d want 2", seen); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({rd, tok_in, out_valid, busy} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_outs: got %b want 0000", {rd, tok_in, out_valid, busy}); end
    rst_n = 1'b1;
    tick();
    run_event(5'd3, 0, 60, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_after_done: got %b want 1", ok); end
    n_cmp++; if (words.size() != 1) begin n_fail++; $display("FAIL mid_after_nwords: got %0d want 1", words.size()); end
    n_cmp++; if (wq(0) !== {1'b1, 5'd3, 24'd0}) begin n_fail++; $display("FAIL mid_after_trailer: got %h want %h", wq(0), {1'b1, 5'd3, 24'd0}); end
  endtask

  task automatic test_back_to_back;
    int n_acc = 0;
    int viol = 0;
    int acc_cyc[2] = '{0, 0};
    words.delete();
    tok_out = 1'b1;
    out_ready = 1'b1;
    req_id = 5'd11;
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (req_ready && busy) viol++;
      if (n_acc == 1) req_id = 5'd12;
      if (req_valid && req_ready) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (out_valid && out_ready) words.push_back(out_data);
      if (n_acc == 2) begin
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy && !out_valid) break;
      if (req_ready && busy) viol++;
      if (out_valid && out_ready) words.push_back(out_data);
      tick();
    end
    n_cmp++; if (n_acc != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", n_acc); end
    n_cmp++; if (acc_cyc[1] - acc_cyc[0] != 6) begin n_fail++; $display("FAIL b2b_gap: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d want 0", viol); end
    n_cmp++; if (words.size() != 2) begin n_fail++; $display("FAIL b2b_nwords: got %0d want 2", words.size()); end
    n_cmp++; if (wq(0) !== {1'b1, 5'd11, 24'd0}) begin n_fail++; $display("FAIL b2b_first: got %h want %h", wq(0), {1'b1, 5'd11, 24'd0}); end
    n_cmp++; if (wq(1) !== {1'b1, 5'd12, 24'd0}) begin n_fail++; $display("FAIL b2b_second: got %h want %h", wq(1), {1'b1, 5'd12, 24'd0}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_valid2 = 1'b0;
    req_id = '0;
    tok_out = 1'b0; tok_out2 = 1'b0;
    data_in = '0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    for (int k = 0; k < 8; k++) hit_tbl[k] = '0;
    test_reset();
    test_empty_event();
    test_three_hits();
    test_backpressure();
    test_timeout();
    test_reset_mid_event();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
